// File: rtl/accumulate_pkg.sv
// accumulate_pkg: shared definitions for the accumulate arbiter.
//   DATA_W         - width of a data word (IEEE-754 single precision)
//   TIMEOUT_CYCLES - cycles WAIT tolerates without acc_done before giving up
//   QNAN           - word returned when the accumulate unit times out
//   state_t        - arbiter FSM state encoding
package accumulate_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned TIMEOUT_CYCLES = 256;
    localparam logic [DATA_W-1:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        FINISH,
        WAIT,
        RESULT
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a registered priority pointer.
//   clk, reset - clock and synchronous active-high reset (pointer favours channel 0)
//   req[1:0]   - request lines
//   update     - pulse: the transaction for 'served' completed, move the pointer
//   served     - one-hot channel that was just served
//   grant      - one-hot combinational grant (zero when no request)
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic [1:0] served,
    output logic [1:0] grant
);

    // ptr = 1 means channel 1 wins a tie
    logic ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (update) begin
            // favour whichever channel was not just served
            ptr <= served[0];
        end
    end

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/accumulate_arbiter.sv
// accumulate_arbiter: shares one accumulate unit between two burst requesters.
// A granted requester streams words into the unit; the returned sum (or a qNaN
// on timeout) is presented on res_data with a one-cycle resN_valid pulse.
//   clk, reset             - clock, synchronous active-high reset
//   reqN_valid/data/last   - requester N word stream (N = 0, 1)
//   reqN_ready             - requester N word accepted at this edge
//   resN_valid             - one-cycle result pulse for requester N
//   res_data, res_err      - last result; res_err marks a timed-out result
//   acc_start/valid/finished, acc_data - control and data to the accumulate unit
//   acc_result, acc_done   - sum and completion from the accumulate unit
//   busy                   - high whenever the FSM is not IDLE
module accumulate_arbiter
    import accumulate_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              res0_valid,
    output logic              res1_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic              acc_start,
    output logic              acc_valid,
    output logic              acc_finished,
    output logic [DATA_W-1:0] acc_data,
    input  logic [DATA_W-1:0] acc_result,
    input  logic              acc_done,
    output logic              busy
);

    state_t            state;
    logic [1:0]        gnt;          // channel owning the current burst
    logic [1:0]        rdy;
    logic [7:0]        wait_cnt;
    logic              done_pend;    // acc_done seen in FINISH, consumed in WAIT
    logic [DATA_W-1:0] pend_result;

    logic [1:0]        arb_grant;
    logic              hs;
    logic              hs_last;
    logic [DATA_W-1:0] hs_data;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({req1_valid, req0_valid}),
        .update (state == RESULT),
        .served (gnt),
        .grant  (arb_grant)
    );

    assign req0_ready = rdy[0];
    assign req1_ready = rdy[1];
    assign busy       = (state != IDLE);

    always_comb begin
        hs      = (rdy[0] & req0_valid) | (rdy[1] & req1_valid);
        hs_last = gnt[1] ? req1_last : req0_last;
        hs_data = gnt[1] ? req1_data : req0_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            gnt          <= 2'b00;
            rdy          <= 2'b00;
            wait_cnt     <= 8'd0;
            done_pend    <= 1'b0;
            pend_result  <= '0;
            acc_start    <= 1'b0;
            acc_valid    <= 1'b0;
            acc_finished <= 1'b0;
            acc_data     <= '0;
            res0_valid   <= 1'b0;
            res1_valid   <= 1'b0;
            res_data     <= '0;
            res_err      <= 1'b0;
        end else begin
            // pulse outputs default low every cycle
            acc_start    <= 1'b0;
            acc_valid    <= 1'b0;
            acc_finished <= 1'b0;
            res0_valid   <= 1'b0;
            res1_valid   <= 1'b0;
            res_err      <= 1'b0;

            case (state)
                IDLE: begin
                    if (|arb_grant) begin
                        gnt       <= arb_grant;
                        acc_start <= 1'b1;
                        state     <= START;
                    end
                end

                START: begin
                    rdy   <= gnt;
                    state <= STREAM;
                end

                STREAM: begin
                    if (hs) begin
                        acc_valid <= 1'b1;
                        acc_data  <= hs_data;
                        if (hs_last) begin
                            rdy   <= 2'b00;
                            state <= FINISH;
                        end
                    end
                end

                // the final acc_valid beat is on the bus in this cycle, so
                // acc_finished is scheduled for the following one
                FINISH: begin
                    acc_finished <= 1'b1;
                    wait_cnt     <= 8'd0;
                    state        <= WAIT;
                    if (acc_done) begin
                        done_pend   <= 1'b1;
                        pend_result <= acc_result;
                    end
                end

                WAIT: begin
                    if (done_pend || acc_done) begin
                        res_data   <= done_pend ? pend_result : acc_result;
                        res0_valid <= gnt[0];
                        res1_valid <= gnt[1];
                        done_pend  <= 1'b0;
                        state      <= RESULT;
                    end else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        res_data   <= QNAN;
                        res_err    <= 1'b1;
                        res0_valid <= gnt[0];
                        res1_valid <= gnt[1];
                        state      <= RESULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                // arbiter pointer moves on this cycle via u_arb.update
                RESULT: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/accumulate_arbiter.md
ACCUMULATE_ARBITER -- requirements
Module: accumulate_arbiter

Interface
REQ-001 SHALL expose clk  input  1  rising-edge system clock; the only clock.
REQ-002 SHALL expose reset  input  1  synchronous, active-high reset.
REQ-003 SHALL expose reqN_valid  input  1  requester N (N=0,1) presents a data word.
REQ-004 SHALL expose reqN_data  input  32  requester N IEEE-754 single-precision word.
REQ-005 SHALL expose reqN_last  input  1  marks final word of requester N burst.
REQ-006 SHALL expose reqN_ready  output  1  word accepted when reqN_valid & reqN_ready at clk edge.
REQ-007 SHALL expose resN_valid  output  1  one-cycle pulse: burst sum for requester N on res_data.
REQ-008 SHALL expose res_data  output  32  last returned sum, held until next result.
REQ-009 SHALL expose res_err  output  1  qualifies resN_valid: result produced by timeout.
REQ-010 SHALL expose acc_start, acc_valid, acc_finished  output  1 each  control to shared accumulate unit.
REQ-011 SHALL expose acc_data  output  32  word to accumulate unit.
REQ-012 SHALL expose acc_result  input  32, acc_done  input  1  sum and completion from accumulate unit.
REQ-013 SHALL expose busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, START, STREAM, FINISH, WAIT, RESULT.
REQ-015 IDLE: if any reqN_valid, SHALL grant one channel and go to START next cycle; otherwise stay.
REQ-016 Arbitration SHALL be round-robin: when both valid, grant the channel not served last; pointer favours channel 0 after reset.
REQ-017 START SHALL drive acc_start=1 for exactly one cycle, acc_valid=0, then enter STREAM.
REQ-018 STREAM: reqN_ready=1 for granted channel only; non-granted ready SHALL be 0 in all states.
REQ-019 Each handshake at edge t SHALL produce acc_valid=1 with acc_data=that word in cycle t+1 (registered, 1-cycle latency); acc_valid=0 in cycles without handshake.
REQ-020 Handshake with reqN_last=1 SHALL move to FINISH; acc_finished=1 for exactly one cycle, the cycle after the last acc_valid beat.
REQ-021 WAIT SHALL sample acc_done; acc_done asserted during FINISH or WAIT SHALL be honoured; acc_done in any other state SHALL be ignored.
REQ-022 On acc_done: capture acc_result into res_data, enter RESULT, pulse granted resN_valid for one cycle with res_err=0, update pointer, return to IDLE.
REQ-023 WAIT timeout: 8-bit counter cleared on entering WAIT; if acc_done absent for 256 cycles SHALL enter RESULT with res_data=32'h7FC00000 (qNaN), res_err=1.
REQ-024 Burst of a single word (valid & last on first handshake) SHALL be legal: one acc_valid beat then acc_finished.
REQ-025 Requests arriving while busy SHALL wait (ready=0); no word SHALL be dropped or duplicated.
REQ-026 acc_start, acc_valid, acc_finished SHALL be mutually exclusive in every cycle.

Reset
REQ-027 reset at any clock edge, including mid-burst or in WAIT, SHALL force IDLE next cycle; all outputs 0, res_data=0, pointer to channel 0, timeout counter 0.
REQ-028 An aborted burst SHALL NOT produce resN_valid; the accumulate unit is re-initialised by the next acc_start.

Structure
REQ-029 Shared package accumulate_pkg SHALL hold the state enum, DATA_W=32, TIMEOUT_CYCLES=256, QNAN=32'h7FC00000.
REQ-030 Round-robin grant SHALL be sub-module rr_arb2 (2 requests, pointer update input, one-hot grant); FSM and datapath live in accumulate_arbiter.

Verification
REQ-031 Bench SHALL model the accumulate unit: sums acc_valid words after acc_start, asserts acc_done 3 cycles after acc_finished.
REQ-032 Ch0 burst 4x 32'h3F800000 -> acc_start once, 4 acc_valid beats, acc_finished once, res0_valid with res_data=32'h40800000, res_err=0.
REQ-033 Ch0 and ch1 valid same cycle after reset, 2x 1.0 each -> ch0 served first (res_data 32'h40000000), then ch1; next tie grants ch0 again.
REQ-034 Ch1 burst with valid gaps (1.0, gap 3 cycles, 1.0 last) -> acc_valid only on handshake cycles, res1_valid with 32'h40000000.
REQ-035 Model never asserts acc_done -> after 256 WAIT cycles res0_valid=1, res_err=1, res_data=32'h7FC00000, busy falls.
REQ-036 reset asserted mid-STREAM after 2 of 4 words -> all outputs 0 next cycle, no resN_valid; fresh 1-word burst 32'h3F800000 then returns 32'h3F800000.
